// File: rtl/cpu_pkg.sv
// Shared definitions for the parameterised multi-cycle CPU: opcodes,
// FSM states, instruction field offsets and small decode helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SHR  = 4'h2,
    OP_SHL  = 4'h3,
    OP_OR   = 4'h4,
    OP_AND  = 4'h5,
    OP_NOT  = 4'h6,
    OP_XOR  = 4'h7,
    OP_JAL  = 4'h8,
    OP_JZ   = 4'h9,
    OP_ST   = 4'hA,
    OP_LD   = 4'hB,
    OP_LI   = 4'hC,
    OP_ADDI = 4'hD,
    OP_JC   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  // Instruction layout: op[15:12] rd[11:8] ra[7:4] rb[3:0], imm8 overlaps ra/rb
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned RB_LSB  = 0;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned IMM_W   = 8;

  function automatic logic is_alu(input opcode_e op);
    return ~op[3];
  endfunction

  function automatic logic is_mem(input opcode_e op);
    return (op == OP_ST) || (op == OP_LD);
  endfunction

  function automatic logic writes_rd(input opcode_e op);
    return is_alu(op) || (op == OP_JAL) || (op == OP_LD) ||
           (op == OP_LI) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes 0000-0111: result, zero and carry/borrow.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] result_o,
  output logic          zero_o,
  output logic          carry_o
);

  localparam int SW = $clog2(DW);
  localparam logic [DW-1:0] DW_V = DW'(DW);

  logic [DW:0] sum;

  // Operation select; shifts by DW or more give zero
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    sum      = '0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DW-1:0];
        carry_o  = sum[DW];
      end
      OP_SUB: begin
        sum      = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum[DW-1:0];
        carry_o  = sum[DW];
      end
      OP_SHR:  if (b_i < DW_V) result_o = a_i >> b_i[SW-1:0];
      OP_SHL:  if (b_i < DW_V) result_o = a_i << b_i[SW-1:0];
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_NOT:  result_o = ~a_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu_param.sv
// Multi-cycle CPU: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with HALT.
// Operands are latched in DECODE, results in EXEC/MEM, and all
// architectural state (PC, registers, flags) commits in WB.
module cpu_param
  import cpu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int NREG = 16
) (
  input  logic          CK,
  input  logic          RST,
  output logic [AW-1:0] IA,
  input  logic [15:0]   ID,
  output logic [AW-1:0] DA,
  output logic [DW-1:0] DOUT,
  input  logic [DW-1:0] DIN,
  output logic          RW,
  output logic          DREQ,
  input  logic          DRDY,
  output logic          HALTED
);

  localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

  function automatic logic [RIW-1:0] ridx(input logic [3:0] f);
    return RIW'(32'(f) % NREG);
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, pc_inc;
  logic [15:0]     ir_q;
  logic [DW-1:0]   a_q, b_q, d_q, res_q, exec_res;
  logic            zn_q, cn_q, z_q, c_q;
  logic [AW-1:0]   da_q;
  logic [DW-1:0]   dout_q;
  logic            rw_q;
  logic [DW-1:0]   regs_q [NREG];

  opcode_e         op;
  logic [RIW-1:0]  rd_idx, ra_idx, rb_idx;
  logic [7:0]      imm;
  logic [DW-1:0]   alu_res;
  logic            alu_zero, alu_carry;

  assign op     = opcode_e'(ir_q[OP_LSB +: FIELD_W]);
  assign rd_idx = ridx(ir_q[RD_LSB +: FIELD_W]);
  assign ra_idx = ridx(ir_q[RA_LSB +: FIELD_W]);
  assign rb_idx = ridx(ir_q[RB_LSB +: FIELD_W]);
  assign imm    = ir_q[IMM_LSB +: IMM_W];
  assign pc_inc = pc_q + AW'(1);

  assign IA   = pc_q;
  assign DA   = da_q;
  assign DOUT = dout_q;
  assign RW   = rw_q;

  cpu_alu #(.DW(DW)) u_alu (
    .op_i     (ir_q[OP_LSB +: FIELD_W]),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry)
  );

  // FSM state register
  always_ff @(posedge CK or posedge RST) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state and state-decoded outputs; DREQ follows state so reset drops it at once
  always_comb begin
    state_d = state_q;
    DREQ    = 1'b0;
    HALTED  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_mem(op))          state_d = S_MEM;
        else if (op == OP_HALT)  state_d = S_HALT;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        DREQ = 1'b1;
        if (DRDY) state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   HALTED  = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

  // Value destined for rd, computed in EXEC from the operands latched in DECODE
  always_comb begin
    exec_res = alu_res;
    case (op)
      OP_JAL:  exec_res = DW'(pc_inc);
      OP_LI:   exec_res = {{(DW-8){1'b0}}, imm};
      OP_ADDI: exec_res = d_q + {{(DW-8){imm[7]}}, imm};
      default: ;
    endcase
  end

  // Next PC; b_q holds the pre-write rb value, so JAL rd==rb jumps to the old value
  always_comb begin
    pc_d = pc_inc;
    case (op)
      OP_JAL:  pc_d = AW'(b_q);
      OP_JZ:   if (z_q) pc_d = AW'(b_q);
      OP_JC:   if (c_q) pc_d = AW'(b_q);
      default: ;
    endcase
  end

  // Datapath registers, memory interface and architectural commit in WB
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      pc_q   <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      res_q  <= '0;
      zn_q   <= 1'b0;
      cn_q   <= 1'b0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      da_q   <= '0;
      dout_q <= '0;
      rw_q   <= 1'b1;
      regs_q <= '{default: '0};
    end else begin
      case (state_q)
        S_FETCH: ir_q <= ID;
        S_DECODE: begin
          a_q <= regs_q[ra_idx];
          b_q <= regs_q[rb_idx];
          d_q <= regs_q[rd_idx];
        end
        S_EXEC: begin
          res_q <= exec_res;
          zn_q  <= alu_zero;
          cn_q  <= alu_carry;
          if (is_mem(op)) begin
            da_q <= AW'(b_q);
            rw_q <= (op == OP_LD);
          end
          if (op == OP_ST) dout_q <= a_q;
        end
        S_MEM: if (DRDY && (op == OP_LD)) res_q <= DIN;
        S_WB: begin
          pc_q <= pc_d;
          if (writes_rd(op)) regs_q[rd_idx] <= res_q;
          if (is_alu(op)) begin
            z_q <= zn_q;
            c_q <= cn_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: a program in a local instruction memory,
// with results observed through IA, the data bus and HALTED.
module tb_cpu_param;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          CK = 1'b0;
  logic          RST;
  logic [AW-1:0] IA;
  logic [15:0]   ID;
  logic [AW-1:0] DA;
  logic [DW-1:0] DOUT;
  logic [DW-1:0] DIN;
  logic          RW;
  logic          DREQ;
  logic          DRDY;
  logic          HALTED;

  logic [15:0]   imem [65536];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CK = ~CK;

  assign ID = imem[IA];

  cpu_param #(.DW(DW), .AW(AW), .NREG(16)) dut (
    .CK     (CK),
    .RST    (RST),
    .IA     (IA),
    .ID     (ID),
    .DA     (DA),
    .DOUT   (DOUT),
    .DIN    (DIN),
    .RW     (RW),
    .DREQ   (DREQ),
    .DRDY   (DRDY),
    .HALTED (HALTED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic do_instr(input string tag, input logic [31:0] next_ia);
    step(4);
    chk(tag, 32'(IA), next_ia);
  endtask

  // Single-cycle-DRDY store: bus checked in MEM, DREQ low in WB, then next IA
  task automatic do_st(input string tag, input logic [31:0] da, input logic [31:0] dout,
                       input logic [31:0] next_ia);
    step(3);
    chk({tag, "_dreq"}, 32'(DREQ), 1);
    chk({tag, "_rw"},   32'(RW),   0);
    chk({tag, "_da"},   32'(DA),   da);
    chk({tag, "_dout"}, 32'(DOUT), dout);
    step(1);
    chk({tag, "_wb_dreq"}, 32'(DREQ), 0);
    step(1);
    chk({tag, "_ia"}, 32'(IA), next_ia);
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) imem[i[15:0]] = 16'hF000;
    // first pass
    imem[16'h0000] = 16'hC105; // LI r1,5
    imem[16'h0001] = 16'hC203; // LI r2,3
    imem[16'h0002] = 16'h0312; // ADD r3,r1,r2
    imem[16'h0003] = 16'h9000; // JZ r0
    imem[16'h0004] = 16'hE000; // JC r0
    imem[16'h0005] = 16'hA030; // ST r3,[r0]
    imem[16'h0006] = 16'hC1FF; // LI r1,0xFF
    imem[16'h0007] = 16'hC208; // LI r2,8
    imem[16'h0008] = 16'h3112; // SHL r1,r1,r2
    imem[16'h0009] = 16'hC701; // LI r7,1
    imem[16'h000A] = 16'h3772; // SHL r7,r7,r2
    imem[16'h000B] = 16'h0317; // ADD r3,r1,r7
    imem[16'h000C] = 16'hC420; // LI r4,0x20
    imem[16'h000D] = 16'hC830; // LI r8,0x30
    imem[16'h000E] = 16'hE004; // JC r4
    imem[16'h0020] = 16'h9008; // JZ r8
    imem[16'h0030] = 16'h4517; // OR r5,r1,r7
    imem[16'h0031] = 16'hC910; // LI r9,0x10
    imem[16'h0032] = 16'hA059; // ST r5,[r9]
    imem[16'h0033] = 16'hB609; // LD r6,[r9]
    imem[16'h0034] = 16'hA060; // ST r6,[r0]
    imem[16'h0035] = 16'h2A59; // SHR r10,r5,r9
    imem[16'h0036] = 16'hA0A9; // ST r10,[r9]
    imem[16'h0037] = 16'h6C00; // NOT r12,r0
    imem[16'h0038] = 16'h1B29; // SUB r11,r2,r9
    imem[16'h0039] = 16'hA0B0; // ST r11,[r0]
    imem[16'h003A] = 16'hE00C; // JC r12
    imem[16'hFFFF] = 16'h0D00; // ADD r13,r0,r0
    // after the mid-MEM reset
    imem[16'h0040] = 16'hA020; // ST r2,[r0]
    imem[16'h0041] = 16'hA060; // ST r6,[r0]
    imem[16'h0042] = 16'hC350; // LI r3,0x50
    imem[16'h0043] = 16'h8303; // JAL r3,r3
    imem[16'h0050] = 16'hA030; // ST r3,[r0]
    imem[16'h0051] = 16'hF000; // HALT

    RST  = 1'b1;
    DRDY = 1'b1;
    DIN  = '0;
    #12;
    chk("rst_ia",     32'(IA),     0);
    chk("rst_dreq",   32'(DREQ),   0);
    chk("rst_rw",     32'(RW),     1);
    chk("rst_da",     32'(DA),     0);
    chk("rst_dout",   32'(DOUT),   0);
    chk("rst_halted", 32'(HALTED), 0);
    RST = 1'b0;

    // LI/LI/ADD, exactly four cycles each
    step(3);
    chk("lat3_ia", 32'(IA), 0);
    step(1);
    chk("li1_ia", 32'(IA), 1);
    do_instr("li2_ia", 2);
    do_instr("add_ia", 3);
    do_instr("jz_nt_ia", 4);
    do_instr("jc_nt_ia", 5);
    do_st("st_r3", 0, 8, 6);

    // shift, ADD carry-out to zero, JC and JZ taken
    do_instr("li_ff_ia", 7);
    do_instr("li_8_ia", 8);
    do_instr("shl_ia", 9);
    do_instr("li_1_ia", 10);
    do_instr("shl2_ia", 11);
    do_instr("add_c_ia", 12);
    do_instr("li_r4_ia", 13);
    do_instr("li_r8_ia", 14);
    do_instr("jc_taken_ia", 32'h20);
    do_instr("jz_taken_ia", 32'h30);
    do_instr("or_ia", 32'h31);
    do_instr("li_r9_ia", 32'h32);

    // store with DRDY low for three sampled edges: four MEM cycles
    DRDY = 1'b0;
    step(3);
    for (int k = 0; k < 4; k++) begin
      chk("stall_dreq", 32'(DREQ), 1);
      chk("stall_rw",   32'(RW),   0);
      chk("stall_da",   32'(DA),   32'h10);
      chk("stall_dout", 32'(DOUT), 32'hFF00);
      if (k < 3) step(1);
    end
    DRDY = 1'b1;
    step(1);
    chk("stall_wb_dreq", 32'(DREQ), 0);
    step(1);
    chk("stall_next_ia", 32'(IA), 32'h33);

    // load with immediate DRDY: five cycles
    DIN = 16'hBEEF;
    step(3);
    chk("ld_dreq", 32'(DREQ), 1);
    chk("ld_rw",   32'(RW),   1);
    chk("ld_da",   32'(DA),   32'h10);
    step(1);
    chk("ld_lat4_ia", 32'(IA), 32'h33);
    step(1);
    chk("ld_lat5_ia", 32'(IA), 32'h34);
    DIN = '0;
    do_st("st_r6", 0, 32'hBEEF, 32'h35);
    do_instr("shr_ia", 32'h36);
    do_st("st_shr16", 32'h10, 0, 32'h37);
    do_instr("not_ia", 32'h38);
    do_instr("sub_ia", 32'h39);
    do_st("st_sub", 0, 32'hFFF8, 32'h3A);
    do_instr("jc_borrow_ia", 32'hFFFF);
    do_instr("pc_wrap_ia", 0);

    // second pass to the store at 5, then reset while it waits in MEM
    do_instr("p2_li1_ia", 1);
    do_instr("p2_li2_ia", 2);
    do_instr("p2_add_ia", 3);
    do_instr("p2_jz_ia", 4);
    do_instr("p2_jc_ia", 5);
    DRDY = 1'b0;
    step(3);
    chk("p2_mem_dreq", 32'(DREQ), 1);
    step(1);
    chk("p2_mem2_dreq", 32'(DREQ), 1);
    #4;
    RST = 1'b1;
    #1;
    chk("midrst_dreq",   32'(DREQ),   0);
    chk("midrst_ia",     32'(IA),     0);
    chk("midrst_rw",     32'(RW),     1);
    chk("midrst_dout",   32'(DOUT),   0);
    chk("midrst_halted", 32'(HALTED), 0);
    imem[16'h0000] = 16'hC140; // LI r1,0x40
    imem[16'h0001] = 16'h8201; // JAL r2,r1
    DRDY = 1'b1;
    #1;
    RST = 1'b0;

    // JAL link, cleared register, JAL with rd==rb, then HALT
    do_instr("r_li_ia", 1);
    do_instr("jal_ia", 32'h40);
    do_st("st_link", 0, 2, 32'h41);
    do_st("st_cleared", 0, 0, 32'h42);
    do_instr("li_r3_ia", 32'h43);
    do_instr("jal_same_ia", 32'h50);
    do_st("st_jal_same", 0, 32'h44, 32'h51);
    step(2);
    chk("pre_halt", 32'(HALTED), 0);
    step(1);
    chk("halted", 32'(HALTED), 1);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("halt_ia", 32'(IA), 32'h51);
    end
    chk("halt_still", 32'(HALTED), 1);
    chk("halt_dreq",  32'(DREQ),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_param.md
CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 Parameter DW, 16, data and register width in bits; DW SHALL be 16 or greater.
REQ-002 Parameter AW, 16, instruction and data address width in bits.
REQ-003 Parameter NREG, 16, register count; NREG SHALL be at most 16, and register fields index modulo NREG.
REQ-004 Port CK  input  1  system clock, rising edge.
REQ-005 Port RST  input  1  reset, asynchronous, active-high.
REQ-006 Port IA  output  AW  instruction address, equal to PC.
REQ-007 Port ID  input  16  instruction word, valid in the FETCH cycle.
REQ-008 Port DA  output  AW  data address.
REQ-009 Port DOUT  output  DW  store data.
REQ-010 Port DIN  input  DW  load data, sampled when DRDY=1.
REQ-011 Port RW  output  1  data direction: 1 = read, 0 = write.
REQ-012 Port DREQ  output  1  data access request.
REQ-013 Port DRDY  input  1  data access complete.
REQ-014 Port HALTED  output  1  high while in the HALT state.

Function
REQ-015 Instruction format SHALL be: op[15:12], rd[11:8], ra[7:4], rb[3:0], imm8[7:0].
REQ-016 Opcodes SHALL be:
- 0000–0111: ADD, SUB, SHR, SHL, OR, AND, NOT(ra), XOR; result goes to rd.
- 1000 JAL: rd<=PC+1, then PC<=rb.
- 1001 JZ: if Z, PC<=rb.
- 1010 ST: mem[rb]<=ra.
- 1011 LD: rd<=mem[rb].
- 1100 LI: rd<=zero-extended imm8.
- 1101 ADDI: rd<=rd+sign-extended imm8.
- 1110 JC: if C, PC<=rb.
- 1111 HALT.
REQ-017 The FSM states SHALL be FETCH->DECODE->EXEC->WB->FETCH; ST/LD SHALL insert MEM between EXEC and WB; HALT SHALL go EXEC->HALT.
REQ-018 Non-memory instructions SHALL take exactly 4 cycles; memory instructions SHALL take 4+N cycles, where N≥1 is the number of MEM cycles up to and including the one with DRDY=1.
REQ-019 In MEM, DREQ SHALL be 1, and DA, DOUT and RW SHALL stay stable until DRDY is sampled 1; DREQ SHALL be 0 in every other state.
REQ-020 Flags Z and C SHALL update in WB for ALU ops 0000–0111 only:
- Z = (result==0).
- C = carry-out for ADD, borrow for SUB, 0 otherwise.
REQ-021 Shift ops SHALL use rb[$clog2(DW)-1:0] only when rb<DW; if rb≥DW the result SHALL be 0.
REQ-022 Address operands SHALL use the low AW bits of the register; PC+1 SHALL wrap modulo 2^AW.
REQ-023 The register file SHALL be written only in WB, and only for ALU, JAL, LD, LI and ADDI; JZ, JC, ST and HALT SHALL write nothing.
REQ-024 A branch not taken SHALL give PC<=PC+1; PC SHALL update only in WB.
REQ-025 JAL with rd==rb SHALL jump to the old rb value.
REQ-026 In HALT, PC and registers SHALL freeze; only RST SHALL leave HALT.

Reset
REQ-027 On RST=1, the block SHALL immediately set: PC=0, state=FETCH, DREQ=0, RW=1, DA=0, DOUT=0, Z=0, C=0, HALTED=0, all registers=0.
REQ-028 RST asserted during MEM SHALL drop DREQ in the same cycle; the aborted instruction SHALL write nothing.

Structure
REQ-029 Package cpu_pkg SHALL hold the opcode constants, the FSM state enum and the instruction-field offsets.
REQ-030 Sub-module cpu_alu SHALL be combinational, parametrised by DW, and produce result, zero and carry.

Verification
REQ-031 LI r1,5; LI r2,3; ADD r3,r1,r2 -> r3=8, Z=0, C=0; each instruction completes 4 cycles after the previous.
REQ-032 LI r1,0xFF; SHL r1,r1,r(=8), then ADD with r1=0xFF00 plus r2=0x0100 -> result 0x0000, Z=1, C=1; a following JC r4 (r4=0x20) -> IA=0x20.
REQ-033 ST r5 to addr 0x10 with DRDY held low 3 cycles -> DREQ=1, RW=0, DA=0x10 stable for 4 cycles; next IA = PC+1 after WB.
REQ-034 LD r6 from 0x10 with DIN=0xBEEF, DRDY=1 on first MEM cycle -> r6=0xBEEF; total latency 5 cycles.
REQ-035 PC=0xFFFF executing ADD -> next IA=0x0000; HALT -> HALTED=1, IA frozen for 20 cycles.
REQ-036 RST pulsed mid-MEM -> DREQ=0 the same cycle, PC=0, no register write observed.
